// File: rtl/barcode_pkg.sv
// Shared types and constants for the station barcode receiver.
package barcode_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_FALL, SAMPLE} state_t;

  localparam int         ID_BITS    = 8;
  localparam logic [1:0] VALID_MASK = 2'b00;
endpackage

// File: rtl/bc_sync.sv
// Two-flop synchronizer (preset high) plus an edge-detect flop for an async pin.
// Edges appear combinationally two clocks after the pin changes; no backpressure.
module bc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic bc_s,
  output logic fall,
  output logic rise
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign bc_s = sync;
  assign fall = prev & ~sync;
  assign rise = ~prev & sync;
endmodule

// File: rtl/barcode_rx.sv
// Self-clocked barcode frame receiver: learns the bit period from the start bit, decodes 8 bits MSB first.
// ID/ID_vld update one clock after the 8th sample; no backpressure, ID_vld is sticky until clr_ID_vld.
module barcode_rx
  import barcode_pkg::*;
#(
  parameter int               TMR_W    = 22,
  parameter logic [TMR_W-1:0] TIMEOUT  = 22'h3FFFFF,
  parameter int               MIN_HALF = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               BC,
  input  logic               clr_ID_vld,
  output logic [ID_BITS-1:0] ID,
  output logic               ID_vld
);
  localparam logic [TMR_W-1:0] MIN_HALF_T = TMR_W'(MIN_HALF);

  logic bc_s;
  logic fall;
  logic rise;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt, timer_inc;
  logic [TMR_W-1:0]   half, half_nxt;
  logic [ID_BITS-1:0] shift, shift_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               eval, eval_nxt;

  bc_sync u_bc_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (BC),
    .bc_s (bc_s),
    .fall (fall),
    .rise (rise)
  );

  // Saturating increment: the timer parks at TIMEOUT rather than wrapping.
  assign timer_inc = (timer == TIMEOUT) ? timer : timer + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      half  <= '0;
      shift <= '0;
      cnt   <= '0;
      eval  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      half  <= half_nxt;
      shift <= shift_nxt;
      cnt   <= cnt_nxt;
      eval  <= eval_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer_inc;
    half_nxt  = half;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    eval_nxt  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = timer;
        if (fall) begin
          timer_nxt = '0;
          state_nxt = START;
        end
      end
      START: begin
        timer_nxt = bc_s ? timer : timer_inc;
        if (timer == TIMEOUT) begin
          state_nxt = IDLE;
        end else if (rise) begin
          // A short low pulse is a glitch, not a start bit.
          if (timer >= MIN_HALF_T) begin
            half_nxt  = timer;
            cnt_nxt   = '0;
            timer_nxt = '0;
            state_nxt = WAIT_FALL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          timer_nxt = '0;
          state_nxt = SAMPLE;
        end else if (timer == TIMEOUT) begin
          state_nxt = IDLE;
        end
      end
      SAMPLE: begin
        if (timer == half) begin
          shift_nxt = {shift[ID_BITS-2:0], bc_s};
          cnt_nxt   = cnt + 1'b1;
          if (cnt == 4'(ID_BITS - 1)) begin
            eval_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            timer_nxt = '0;
            state_nxt = WAIT_FALL;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completing valid frame takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID     <= '0;
      ID_vld <= 1'b0;
    end else if (eval && (shift[ID_BITS-1:ID_BITS-2] == VALID_MASK)) begin
      ID     <= shift;
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end
endmodule
